mem3_rr_arbiter: RTL

//  Shares one pseudo-2-port triple-word memory (one 3-word read group + one 3-word write group per cycle) between N_REQ requesters.

---
 rtl/mem3_rr_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem3_rr_arbiter.sv
// mem3_rr_arbiter: round-robin sharing of a pseudo-2-port triple-word memory between N_REQ requesters.
// Define MEM3_ARB_STATS_EN to add saturating grant/stall counters.
module mem3_rr_arbiter #(
   parameter int  WIDTH  = 16,
   parameter int  HEIGHT = 64,
   parameter int  N_REQ  = 2,
   localparam int AW     = $clog2(HEIGHT)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           rd_req_valid,
   input  logic [N_REQ*AW-1:0]        rd_req_addr,
   output logic [N_REQ-1:0]           rd_req_ready,
   output logic [N_REQ-1:0]           rd_rsp_valid,
   output logic [3*WIDTH-1:0]         rd_rsp_data,
   input  logic [N_REQ-1:0]           wr_req_valid,
   input  logic [N_REQ*AW-1:0]        wr_req_addr,
   input  logic [N_REQ*3*WIDTH-1:0]   wr_req_data,
   output logic [N_REQ-1:0]           wr_req_ready,
   output logic [AW-1:0]              mem_read_addr,
   output logic                       mem_read_en,
   input  logic [3*WIDTH-1:0]         mem_q,
   output logic [AW-1:0]              mem_write_addr,
   output logic                       mem_write_en,
   output logic [3*WIDTH-1:0]         mem_din,
   input  logic                       flush,
   output logic                       flush_done,
   output logic                       addr_err
`ifdef MEM3_ARB_STATS_EN
   ,
   output logic [31:0]                stat_rd_grants,
   output logic [31:0]                stat_wr_grants,
   output logic [31:0]                stat_stall_cycles
`endif
);
   localparam int PW = $clog2(N_REQ);
   localparam logic [AW-1:0] MAX_BASE = AW'(HEIGHT-3);

   typedef enum logic [1:0] {RUN, DRAIN, DONE, HOLD} state_t;

   state_t             r_state, w_state_nxt;
   logic [PW-1:0]      r_rd_ptr, r_wr_ptr, w_rd_idx, w_wr_idx;
   logic [AW-1:0]      w_rd_addr, w_wr_addr;
   logic               w_gnt_en, w_rd_go, w_wr_go, w_rd_oor, w_wr_oor;
   logic [N_REQ-1:0]   r_rsp_valid;
   logic [3*WIDTH-1:0] r_rsp_data;
   logic               r_addr_err;

   // first valid requester at or after the pointer, scanning cyclically
   function automatic logic [PW-1:0] rr_idx(input logic [N_REQ-1:0] v, input logic [PW-1:0] p);
      rr_idx = p;
      for (int k = N_REQ-1; k >= 0; k--)
         if (v[PW'((int'(p) + k) % N_REQ)]) rr_idx = PW'((int'(p) + k) % N_REQ);
   endfunction

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (int'(p) == N_REQ-1) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) r_state <= RUN;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:     w_state_nxt = flush ? DRAIN : RUN;
         DRAIN:   w_state_nxt = (r_rsp_valid == '0) ? DONE : DRAIN;
         DONE:    w_state_nxt = HOLD;
         HOLD:    w_state_nxt = flush ? HOLD : RUN;
         default: w_state_nxt = RUN;
      endcase
   end

   always_comb begin
      w_gnt_en   = (r_state == RUN) && !flush && !reset;
      flush_done = (r_state == DONE);
   end

   always_comb begin
      w_rd_idx       = rr_idx(rd_req_valid, r_rd_ptr);
      w_wr_idx       = rr_idx(wr_req_valid, r_wr_ptr);
      w_rd_addr      = rd_req_addr[w_rd_idx*AW +: AW];
      w_wr_addr      = wr_req_addr[w_wr_idx*AW +: AW];
      w_rd_go        = w_gnt_en && |rd_req_valid;
      w_wr_go        = w_gnt_en && |wr_req_valid;
      w_rd_oor       = w_rd_addr > MAX_BASE;
      w_wr_oor       = w_wr_addr > MAX_BASE;
      rd_req_ready   = w_rd_go ? N_REQ'(1) << w_rd_idx : '0;
      wr_req_ready   = w_wr_go ? N_REQ'(1) << w_wr_idx : '0;
      mem_read_en    = w_rd_go && !w_rd_oor;
      mem_write_en   = w_wr_go && !w_wr_oor;
      mem_read_addr  = mem_read_en ? w_rd_addr : '0;
      mem_write_addr = mem_write_en ? w_wr_addr : '0;
      mem_din        = mem_write_en ? wr_req_data[w_wr_idx*3*WIDTH +: 3*WIDTH] : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_addr_err  <= 1'b0;
      end else begin
         r_rsp_valid <= rd_req_ready;
         if (w_rd_go) begin
            r_rd_ptr   <= inc(w_rd_idx);
            r_rsp_data <= w_rd_oor ? '0 : mem_q;
         end
         if (w_wr_go) r_wr_ptr <= inc(w_wr_idx);
         if ((w_rd_go && w_rd_oor) || (w_wr_go && w_wr_oor)) r_addr_err <= 1'b1;
      end
   end

   assign rd_rsp_valid = r_rsp_valid;
   assign rd_rsp_data  = r_rsp_data;
   assign addr_err     = r_addr_err;

`ifdef MEM3_ARB_STATS_EN
   logic w_stall;
   assign w_stall = |(rd_req_valid & ~rd_req_ready) || |(wr_req_valid & ~wr_req_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_rd_grants    <= '0;
         stat_wr_grants    <= '0;
         stat_stall_cycles <= '0;
      end else begin
         if (w_rd_go && !(&stat_rd_grants)) stat_rd_grants <= stat_rd_grants + 32'd1;
         if (w_wr_go && !(&stat_wr_grants)) stat_wr_grants <= stat_wr_grants + 32'd1;
         if (w_stall && !(&stat_stall_cycles)) stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
   end
`endif
endmodule
